// File: rtl/conn_pkg.sv
// Shared types for the connection responder: FSM state encoding and pointer sizing.
package conn_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // One extra bit beyond the index so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/conn_echo_responder_if.sv
// Request/response valid-ready link between the bench-side master and the responder.
interface conn_echo_responder_if #(
  parameter int width = 1
);
  logic             req_valid;
  logic             req_ready;
  logic [width-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [width-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/conn_fifo.sv
// Circular FIFO with registered head; a pushed word is visible after the write edge.
// No internal flow control: caller must never push when full or pop when empty.
module conn_fifo
  import conn_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [width-1:0]          push_data,
  input  logic                      pop,
  output logic [width-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(depth)-1:0]   level
);

  localparam int pw = ptr_w(depth);
  localparam int aw = pw - 1;

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [width-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + pw'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + pw'(1);
        last_q <= mem[rd_ptr[aw-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[aw-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign level = wr_ptr - rd_ptr;
  // While empty, keep presenting the last word popped rather than a stale slot.
  assign head  = empty ? last_q : mem[rd_ptr[aw-1:0]];

endmodule

// File: rtl/conn_echo_responder.sv
// Echoes each request word in order through a FIFO; first-word latency 1 cycle.
// req_ready drops when full or while a drain is in progress; responses wait on rsp_ready.
module conn_echo_responder
  import conn_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 4,
  parameter int cnt_w = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  conn_echo_responder_if.slave     link,
  input  logic                     drain,
  output logic                     drained,
  output logic [cnt_w-1:0]         rsp_count,
  output logic [ptr_w(depth)-1:0]  level
);

  localparam int pw = ptr_w(depth);

  state_t state;
  state_t state_nxt;
  logic   up;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  // up keeps req_ready low while reset is held and until the first edge after it.
  assign link.req_ready = up && (state == RUN) && !full;
  assign link.rsp_valid = !empty;
  assign push = link.req_valid && link.req_ready;
  assign pop  = link.rsp_valid && link.rsp_ready;

  conn_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (link.req_data),
    .pop       (pop),
    .head      (link.rsp_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      up        <= 1'b0;
      rsp_count <= '0;
    end else begin
      state <= state_nxt;
      up    <= 1'b1;
      if (pop) rsp_count <= rsp_count + cnt_w'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    drained   = 1'b0;
    case (state)
      RUN:   if (drain) state_nxt = DRAIN;
      // Intake is closed here, so level==1 with a pop means the last word leaves now.
      DRAIN: if (empty || (level == pw'(1) && pop)) state_nxt = DONE;
      DONE: begin
        drained   = 1'b1;
        state_nxt = drain ? HOLD : RUN;
      end
      HOLD:  if (!drain) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_conn_echo_responder.sv
// Scoreboarded bench for conn_echo_responder (width 8, depth 4).
module tb_conn_echo_responder;

  logic        clk;
  logic        rst_n;
  logic        drain;
  logic        drained;
  logic [15:0] rsp_count;
  logic [2:0]  level;

  int n_checks;
  int n_fail;
  logic [7:0] sb[$];

  conn_echo_responder_if #(.width(8)) bus ();

  conn_echo_responder #(
    .width (8),
    .depth (4),
    .cnt_w (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (bus),
    .drain     (drain),
    .drained   (drained),
    .rsp_count (rsp_count),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; the monitor samples settled values at negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) sb.push_back(bus.req_data);
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got rsp_data=%h, required no response", bus.rsp_data);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (bus.rsp_data !== exp) begin
            n_fail++;
            $display("FAIL sb_data: got rsp_data=%h, required %h", bus.rsp_data, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n words base, base+1, ... and run until all are accepted and returned.
  task automatic run_words(input int n, input logic [7:0] base, input int rmode, input int budget);
    int   sent;
    int   cyc;
    logic was;
    sent = 0;
    cyc  = 0;
    while ((sent < n || sb.size() != 0) && cyc < budget) begin
      bus.rsp_ready = (rmode == 1) ? cyc[0] : 1'b1;
      bus.req_valid = (sent < n);
      bus.req_data  = base + 8'(sent);
      was = bus.req_valid && bus.req_ready;
      tick();
      if (was) sent++;
      cyc++;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL run_timeout: sent=%0d pending=%0d, required all %0d returned", sent, sb.size(), n);
    end
  endtask

  // Offer words with rsp_ready low; returns how many were accepted within cycles.
  task automatic fill(input logic [7:0] base, input int want, input int cycles, output int acc);
    logic was;
    acc = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < cycles && acc < want; c++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = base + 8'(acc);
      was = bus.req_ready;
      tick();
      if (was) acc++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drain = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    #3;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h, required 00", bus.rsp_data); end
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL rst_drained: got %b, required 0", drained); end
    n_checks++; if (rsp_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", rsp_count); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d, required 0", level); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b, required 1", bus.req_ready); end
  endtask

  task automatic test_stream();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h11;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h11) begin
      n_fail++; $display("FAIL stream_latency: got valid=%b data=%h, required 1/11", bus.rsp_valid, bus.rsp_data);
    end
    bus.req_data = 8'h22;
    tick();
    n_checks++; if (bus.rsp_data !== 8'h22) begin n_fail++; $display("FAIL stream_second: got %h, required 22", bus.rsp_data); end
    bus.req_data = 8'h33;
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (rsp_count !== 16'd3) begin n_fail++; $display("FAIL stream_count: got %0d, required 3", rsp_count); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL stream_level: got %0d, required 0", level); end
  endtask

  task automatic test_full();
    int acc;
    fill(8'h40, 6, 8, acc);
    n_checks++; if (acc != 4) begin n_fail++; $display("FAIL full_accepted: got %0d, required 4", acc); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d, required 4", level); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h40) begin
      n_fail++; $display("FAIL full_head: got valid=%b data=%h, required 1/40", bus.rsp_valid, bus.rsp_data);
    end
    run_words(2, 8'h44, 0, 50);
    n_checks++; if (rsp_count !== 16'd9) begin n_fail++; $display("FAIL full_count: got %0d, required 9", rsp_count); end
  endtask

  task automatic test_wrap();
    run_words(10, 8'h60, 1, 200);
    n_checks++; if (rsp_count !== 16'd19) begin n_fail++; $display("FAIL wrap_count: got %0d, required 19", rsp_count); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL wrap_level: got %0d, required 0", level); end
  endtask

  task automatic test_drain();
    int acc;
    int pulses;
    fill(8'h51, 3, 10, acc);
    drain = 1'b1;
    tick();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b, required 0", bus.req_ready); end
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL drain_level: got %0d, required 3", level); end
    bus.rsp_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (drained) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL drain_pulses: got %0d, required 1", pulses); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d, required 0", level); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b, required 0", bus.req_ready); end
    n_checks++; if (rsp_count !== 16'd22) begin n_fail++; $display("FAIL drain_count: got %0d, required 22", rsp_count); end
    drain = 1'b0;
    tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b, required 1", bus.req_ready); end
  endtask

  task automatic test_drain_empty();
    bus.req_data = 8'hxx;
    drain = 1'b1;
    tick();
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL dempty_t1: got %b, required 0", drained); end
    tick();
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL dempty_t2: got %b, required 1", drained); end
    n_checks++; if (bus.rsp_valid !== 1'b0 || $isunknown(bus.rsp_data)) begin
      n_fail++; $display("FAIL dempty_rsp: got valid=%b data=%h, required 0 and known data", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL dempty_t3: got %b, required 0", drained); end
    drain = 1'b0;
    bus.req_data = 8'h00;
    tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL dempty_ready: got %b, required 1", bus.req_ready); end
  endtask

  task automatic test_async_reset();
    int acc;
    fill(8'h71, 2, 6, acc);
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL ar_level_pre: got %0d, required 2", level); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b, required 0", bus.rsp_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL ar_level: got %0d, required 0", level); end
    n_checks++; if (rsp_count !== 16'd0) begin n_fail++; $display("FAIL ar_count: got %0d, required 0", rsp_count); end
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    run_words(1, 8'hA5, 0, 20);
    n_checks++; if (rsp_count !== 16'd1) begin n_fail++; $display("FAIL ar_post_count: got %0d, required 1", rsp_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_full();
    test_wrap();
    test_drain();
    test_drain_empty();
    test_async_reset();
    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
